// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_pkg
// Desc     : Shared widths, defaults and helpers for the MIPS core datapath
//            and the store buffer sitting on its data-memory write port.
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam int WORD_W          = 32;
    localparam int STORE_BUF_DEPTH = 4;

    // Word address of a byte address; stores are word-only, so the byte
    // offset never takes part in an address compare.
    function automatic logic [WORD_W-3:0] word_addr(input logic [WORD_W-1:0] a);
        return a[WORD_W-1:2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module   : sb_fwd_lookup
// Desc     : Combinational newest-match search over the store buffer entries.
//            Returns the data of the most recently enqueued valid entry whose
//            word address matches the lookup address.
// Revision : 1.0 - initial release
// ============================================================================
module sb_fwd_lookup #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       lookup_en,
    input  logic [AW-3:0]              lookup_waddr,
    input  logic [AW-3:0]              entry_waddr [DEPTH],
    input  logic [DW-1:0]              entry_data  [DEPTH],
    input  logic [DEPTH-1:0]           valid,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    input  logic [$clog2(DEPTH)-1:0]   wr_ptr,
    output logic                       hit,
    output logic [DW-1:0]              data
);

    localparam int c_PW = $clog2(DEPTH);

    logic [c_PW-1:0] w_idx;

    // The scan is anchored on the head and walks towards the tail, so the
    // valid mask alone bounds it; the tail pointer is not needed here.
    logic w_unused_wr_ptr;
    assign w_unused_wr_ptr = ^wr_ptr;

    // Walk oldest to newest; a later match overwrites an earlier one so the
    // entry closest to the tail wins.
    always_comb begin
        hit   = 1'b0;
        data  = '0;
        w_idx = '0;
        if (lookup_en) begin
            for (int k = 0; k < DEPTH; k++) begin
                w_idx = rd_ptr + c_PW'(k);
                if (valid[w_idx] && (entry_waddr[w_idx] == lookup_waddr)) begin
                    hit  = 1'b1;
                    data = entry_data[w_idx];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Desc     : In-order write buffer between the single-cycle core's data
//            write port and a slower valid/ready backing memory. Stalls the
//            core only when full and forwards the newest buffered data to
//            same-address loads.
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
    import mips_pkg::*;
#(
    parameter int DEPTH = STORE_BUF_DEPTH,
    parameter int AW    = WORD_W,
    parameter int DW    = WORD_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    input  logic                     memread,
    output logic                     stall,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic                     mem_valid,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int c_PW  = $clog2(DEPTH);
    localparam int c_CW  = c_PW + 1;
    localparam int c_WAW = AW - 2;

    logic [c_WAW-1:0] r_addr [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    logic [c_PW-1:0]  r_wr_ptr;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;
    logic [c_WAW-1:0] w_waddr;
    logic [DEPTH-1:0] w_valid;

    // Word address of the current core access (store or load).
    if (AW == WORD_W) begin : g_pkg_waddr
        assign w_waddr = word_addr(dataadr);
    end else begin : g_slice_waddr
        assign w_waddr = dataadr[AW-1:2];
    end

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);

    // Full blocks the store even when the head drains this same cycle; the
    // core simply re-presents it and it is taken on the next edge.
    assign w_enq = memwrite & ~w_full;
    assign w_deq = ~w_empty & mem_ready;

    // Pointer and occupancy bookkeeping; reset drops any pending entries
    // along with a transfer handshaking on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; contents are don't-care until made valid by an enqueue.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_wr_ptr] <= w_waddr;
            r_data[r_wr_ptr] <= writedata;
        end
    end

    // An entry is valid when its distance from the head is below occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_valid
        logic [c_PW-1:0] w_off;
        assign w_off      = c_PW'(i) - r_rd_ptr;
        assign w_valid[i] = ({1'b0, w_off} < r_count);
    end

    sb_fwd_lookup #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (DW)
    ) u_fwd_lookup (
        .lookup_en    (memread),
        .lookup_waddr (w_waddr),
        .entry_waddr  (r_addr),
        .entry_data   (r_data),
        .valid        (w_valid),
        .rd_ptr       (r_rd_ptr),
        .wr_ptr       (r_wr_ptr),
        .hit          (fwd_hit),
        .data         (fwd_data)
    );

    assign stall     = memwrite & w_full;
    assign mem_valid = ~w_empty;
    assign mem_addr  = {r_addr[r_rd_ptr], 2'b00};
    assign mem_wdata = r_data[r_rd_ptr];
    assign count     = r_count;
    assign empty     = w_empty;

endmodule
`default_nettype wire
